// File: rtl/usb_button_scheduler.sv
// Button front-end for usb_controller: synchronise, debounce, queue presses as events,
// and replay each event as a reset-release window with one button driven.
module usb_button_scheduler #(
    parameter int DEB_CYCLES = 4,
    parameter int PAR_HOLD   = 4,
    parameter int SER_HOLD   = 16,
    parameter int GAP        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [7:0] btn_in,
    output logic       ctl_reset,
    output logic       ctl_mode,
    output logic [7:0] ctl_btn,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HOLD_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

    logic [7:0]        sync_p0, sync_p1;
    logic [7:0]        level_p2, level_d;
    logic [7:0]        deb_cnt [8];
    logic [7:0]        pending, rise, grant;
    logic [2:0]        grant_idx;
    logic              found, push, pop;
    logic [2:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [2:0]        evt;
    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              mode_n;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-bit debounce; the level only moves after DEB_CYCLES disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_p2 <= '0;
            level_d  <= '0;
            for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
        end else begin
            level_d <= level_p2;
            for (int i = 0; i < 8; i++) begin
                if (sync_p1[i] == level_p2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == 8'(DEB_CYCLES - 1)) begin
                    level_p2[i] <= sync_p1[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign rise = level_p2 & ~level_d;

    // Fixed-priority arbiter: lowest pending index wins, held off while the queue is full
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i] && !found) begin
                grant_idx = 3'(i);
                found     = 1'b1;
            end
        end
        push  = found && !fifo_full;
        grant = push ? (8'b1 << grant_idx) : 8'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~grant) | rise;
            overflow <= overflow | (|(rise & pending));
        end
    end

    // Event queue: pointers and occupancy carry the control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant_idx;
        if (pop)  evt <= fifo_mem[rd_ptr];
    end

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Replay FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            ctl_mode <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            ctl_mode <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        mode_n  = ctl_mode;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    mode_n  = mode;
                    hold_n  = mode ? HOLD_W'(SER_HOLD - 1) : HOLD_W'(PAR_HOLD - 1);
                    state_n = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt == '0) begin
                    hold_n  = HOLD_W'(GAP - 1);
                    state_n = ST_GAP;
                end else begin
                    hold_n = hold_cnt - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (hold_cnt == '0) state_n = ST_IDLE;
                else                hold_n  = hold_cnt - HOLD_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign ctl_reset = (state != ST_ASSERT);
    assign ctl_btn   = (state == ST_ASSERT) ? (8'b1 << evt) : 8'b0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_usb_button_scheduler.sv
// Directed bench for usb_button_scheduler with default parameters.
module tb_usb_button_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [7:0] btn_in;
    logic       ctl_reset, ctl_mode, busy, fifo_full, fifo_empty, overflow;
    logic [7:0] ctl_btn;

    int         passed = 0;
    int         total  = 0;
    int         base;
    logic [7:0] ev_q[$];
    logic [7:0] prev_btn;

    usb_button_scheduler dut (
        .clk(clk), .reset(reset), .mode(mode), .btn_in(btn_in),
        .ctl_reset(ctl_reset), .ctl_mode(ctl_mode), .ctl_btn(ctl_btn),
        .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample 1 time unit after the edge, check invariants, log window starts
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot_when_released",
              32'($onehot0(ctl_btn) && !(ctl_reset && ctl_btn != 8'h00)), 32'd1);
        if (ctl_btn != 8'h00 && prev_btn == 8'h00) ev_q.push_back(ctl_btn);
        prev_btn = ctl_btn;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl_reset"}, ctl_reset, 1);
        check({tag, "_ctl_mode"}, ctl_mode, 0);
        check({tag, "_ctl_btn"}, ctl_btn, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fifo_full"}, fifo_full, 0);
        check({tag, "_fifo_empty"}, fifo_empty, 1);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; btn_in = 8'h00; prev_btn = 8'h00;
        tick(); tick();
        check_reset_outputs("init");
        reset = 1'b0;
        repeat (3) tick();

        // Single press, parallel mode: button rises at edge 9 for 4 cycles
        base = ev_q.size();
        btn_in = 8'h01;
        repeat (8) tick();
        check("par_before_edge9", ctl_btn, 8'h00);
        tick();
        check("par_btn_edge9", ctl_btn, 8'h01);
        check("par_ctl_reset", ctl_reset, 0);
        check("par_ctl_mode", ctl_mode, 0);
        check("par_busy", busy, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("par_hold", ctl_btn, 8'h01);
        end
        tick();
        check("par_gap1_btn", ctl_btn, 8'h00);
        check("par_gap1_reset", ctl_reset, 1);
        check("par_gap1_busy", busy, 1);
        tick();
        check("par_gap2_reset", ctl_reset, 1);
        check("par_gap2_busy", busy, 1);
        tick();
        check("par_idle_busy", busy, 0);
        repeat (5) tick();
        btn_in = 8'h00;
        repeat (20) tick();
        check("par_event_count", ev_q.size() - base, 1);
        check("par_event_btn", ev_q[base], 8'h01);
        check("par_end_empty", fifo_empty, 1);

        // Serial mode, Y; mode toggled mid-window must not reach ctl_mode
        base = ev_q.size();
        mode = 1'b1;
        btn_in = 8'h80;
        repeat (8) tick();
        check("ser_before", ctl_btn, 8'h00);
        tick();
        check("ser_btn_first", ctl_btn, 8'h80);
        check("ser_mode_first", ctl_mode, 1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("ser_hold_btn", ctl_btn, 8'h80);
            check("ser_hold_mode", ctl_mode, 1);
            if (i == 5) mode = 1'b0;
        end
        tick();
        check("ser_after_btn", ctl_btn, 8'h00);
        check("ser_after_reset", ctl_reset, 1);
        btn_in = 8'h00;
        repeat (20) tick();
        check("ser_event_count", ev_q.size() - base, 1);
        check("ser_busy_end", busy, 0);

        // Bounce on A, then a lone 3-cycle glitch
        mode = 1'b0;
        base = ev_q.size();
        repeat (2) begin
            btn_in = 8'h10; repeat (3) tick();
            btn_in = 8'h00; repeat (3) tick();
        end
        btn_in = 8'h10;
        repeat (30) tick();
        check("bounce_event_count", ev_q.size() - base, 1);
        check("bounce_event_btn", ev_q[base], 8'h10);
        btn_in = 8'h00;
        repeat (20) tick();
        base = ev_q.size();
        btn_in = 8'h10; repeat (3) tick();
        btn_in = 8'h00; repeat (25) tick();
        check("glitch_no_event", ev_q.size() - base, 0);
        check("glitch_busy", busy, 0);

        // U+D together: U window, 3 released cycles, D window
        base = ev_q.size();
        btn_in = 8'h0C;
        repeat (8) tick();
        for (int i = 9; i <= 12; i++) begin
            tick();
            check("sim_u_window", ctl_btn, 8'h04);
        end
        for (int i = 13; i <= 15; i++) begin
            tick();
            check("sim_sep_reset", ctl_reset, 1);
            check("sim_sep_btn", ctl_btn, 8'h00);
        end
        for (int i = 16; i <= 19; i++) begin
            tick();
            check("sim_d_window", ctl_btn, 8'h08);
        end
        check("sim_overflow", overflow, 0);
        repeat (11) tick();
        btn_in = 8'h00;
        repeat (20) tick();
        check("sim_event_count", ev_q.size() - base, 2);
        check("sim_event0", ev_q[base], 8'h04);
        check("sim_event1", ev_q[base + 1], 8'h08);

        // All eight in serial mode: back-pressure, then a lost Y re-press
        mode = 1'b1;
        base = ev_q.size();
        btn_in = 8'hFF;
        repeat (11) tick();
        check("bp_not_full_yet", fifo_full, 0);
        tick();
        check("bp_full", fifo_full, 1);
        check("bp_busy", busy, 1);
        repeat (2) tick();
        btn_in = 8'h7F;
        repeat (10) tick();
        check("bp_no_overflow_yet", overflow, 0);
        btn_in = 8'hFF;
        repeat (16) tick();
        check("bp_overflow_set", overflow, 1);
        repeat (160) tick();
        check("bp_done_busy", busy, 0);
        check("bp_done_empty", fifo_empty, 1);
        check("bp_overflow_sticky", overflow, 1);
        check("bp_event_count", ev_q.size() - base, 8);
        for (int k = 0; k < 8; k++)
            check("bp_event_order", ev_q[base + k], 32'(1) << k);
        btn_in = 8'h00;
        repeat (20) tick();
        check("bp_release_no_event", ev_q.size() - base, 8);

        // Asynchronous reset in the middle of a window with a queued event
        mode = 1'b0;
        base = ev_q.size();
        btn_in = 8'h03;
        repeat (10) tick();
        check("rst_mid_btn", ctl_btn, 8'h01);
        check("rst_mid_queued", fifo_empty, 0);
        reset = 1'b1;
        #2;
        check_reset_outputs("async");
        btn_in = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("rst_after_busy", busy, 0);
        check("rst_after_empty", fifo_empty, 1);
        check("rst_after_count", ev_q.size() - base, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/usb_button_scheduler.md
Name: usb_button_scheduler

Overview:
Front-end sequencer that sits between the raw gamepad buttons and usb_controller. It synchronises and debounces the eight buttons, and queues each press as an event. It then replays events to usb_controller one at a time. Each event is a reset-release window with a single button asserted, held for a mode-dependent length that covers a full parallel (mode 0) or serial (mode 1) frame.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level (1..255)
PAR_HOLD, 4, cycles a button is driven to the controller in mode 0 (parallel)
SER_HOLD, 16, cycles a button is driven to the controller in mode 1 (serial frame length)
GAP, 2, cycles ctl_reset is held high between consecutive events (>=1)
FIFO_DEPTH, 4, event queue depth (power of two)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = parallel/gaming, 1 = serial/navigation; sampled at dispatch
btn_in  in  8  raw buttons, bit order {Y,X,B,A,D,U,R,L} (bit0 = L)
ctl_reset  out  1  reset to usb_controller
ctl_mode  out  1  mode to usb_controller
ctl_btn  out  8  one-hot button drive to usb_controller, same bit order
busy  out  1  high when FSM not in IDLE
fifo_full  out  1  event queue full
fifo_empty  out  1  event queue empty
overflow  out  1  sticky: a press was lost

Behaviour:
- Reset (async) clears sync flops, debounce counters/levels, pending mask, FIFO, FSM→IDLE. Outputs: ctl_reset=1, ctl_mode=0, ctl_btn=0, busy=0, fifo_full=0, fifo_empty=1, overflow=0. Reset asserted mid-event aborts the event immediately; queued events are discarded.
- Sync: each btn_in bit uses a 2-flop synchroniser.
- Debounce: one 8-bit counter per bit. The counter resets when the sync value equals the debounced level, else increments. When it reaches DEB_CYCLES, the level takes the sync value and the counter clears. Glitches shorter than DEB_CYCLES cycles are ignored.
- Edge capture: a debounced 0→1 sets pending[i] on the next edge. A rising edge on a bit whose pending[i] is already set sets overflow; the pending bit stays set.
- Arbiter: each cycle, if pending≠0 and FIFO not full, push the 3-bit index of the lowest set pending bit and clear that bit. Priority is fixed L>R>U>D>A>B>X>Y. One push per cycle. While the FIFO is full, pending bits wait (back-pressure, no loss).
- FIFO: synchronous, FIFO_DEPTH×3 bits. A push while full is impossible by construction. A pop and a push in the same cycle are both honoured.
- Nominal latency: a clean raw press raises ctl_btn at the (DEB_CYCLES+5)th rising edge after the first edge that samples it, when the FSM is idle with FIFO empty and pending=0. Stages: 2 sync, DEB_CYCLES debounce, pending, push, dispatch.
- FSM:
  - IDLE: ctl_reset=1, ctl_btn=0. If FIFO not empty: pop, latch ctl_mode←mode, load hold counter with (mode ? SER_HOLD : PAR_HOLD)−1, go to ASSERT.
  - ASSERT: ctl_reset=0, ctl_btn=one-hot(event). Hold counter decrements; at 0 go to GAP and load the counter with GAP−1. The button is driven for exactly PAR_HOLD or SER_HOLD cycles.
  - GAP: ctl_reset=1, ctl_btn=0. Counter decrements; at 0 return to IDLE.
- Back-to-back events: IDLE lasts 1 cycle, so consecutive ASSERT windows are separated by GAP+1 cycles with ctl_reset=1.
- ctl_mode changes only at dispatch. A mode toggle during ASSERT or GAP has no effect until the next event.
- ctl_btn is never more than one-hot and is always 0 when ctl_reset=1.
- Simultaneous presses become separate events in priority order. Pressing U and D together yields a U event then a D event, never a two-hot drive.
- Releases generate no events. Holding a button generates one event.

Test Plan:
- Reset: assert reset mid-ASSERT → all outputs return to reset values in the same cycle with no clock edge; FIFO empty afterwards.
- Single press, mode=0, defaults: btn_in=8'h01 held 20 cycles → ctl_btn=8'h01 from edge 9 for exactly 4 cycles with ctl_reset=0 and ctl_mode=0; then 2 cycles ctl_reset=1; busy deasserts.
- Serial mode: mode=1, btn_in=8'h80 (Y) → ctl_btn=8'h80 for exactly 16 cycles, ctl_mode=1. Toggle mode to 0 at hold cycle 5 → ctl_mode stays 1.
- Bounce: 3-cycle pulses on A separated by 3-cycle gaps, then a stable level → exactly one A event; a 3-cycle glitch alone → no event.
- Simultaneous: btn_in=8'h0C (U+D) in one cycle → U window (8'h04) then D window (8'h08), separated by 3 cycles of ctl_reset=1; overflow=0.
- Overflow and back-pressure, mode=1: press all 8 buttons together → 4 events queue, fifo_full=1, the rest wait in pending; all 8 eventually play out in order L..Y. A re-press of Y while pending[7] is set sets overflow=1, which stays set until reset.
